// File: rtl/multi_timer.sv
// ----------------------------------------------------------------------------
// multi_timer
//
// Multi-channel interval timer on a 32-bit Avalon-MM slave. Each channel has
// an 8-bit prescaler, a CNT_W-bit down-counter reloaded from PERIOD, one-shot
// or continuous operation, a COMPARE register driving a PWM output, and
// sticky timeout (TO) and compare (CF) flags. All enabled channel flags are
// OR'ed into a single level interrupt.
//
// Per-channel register map (word offset, 8-word stride per channel):
//   0 STATUS  : bit0 TO (W1C), bit1 RUN (RO), bit2 CF (W1C)
//   1 CONTROL : bit0 ITO, bit1 CONT, bit2 START (strobe), bit3 STOP (strobe),
//               bit4 ICF, bit5 PWM_EN, [15:8] PRESC
//   2 PERIOD  : read/write; a write force-reloads COUNT and stops the channel
//   3 COMPARE : read/write
//   4 COUNT   : read-only live counter
//   5..7      : read 0
//
// Ports:
//   clk        : clock, all logic on the rising edge
//   reset_n    : asynchronous active-low reset
//   address    : word address, [2:0] register offset, upper bits channel
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data
//   readdata   : registered read data, 1-cycle latency, no side effects
//   irq        : level interrupt, OR of (TO&ITO)|(CF&ICF) over channels
//   pwm_out    : per-channel registered PWM output
// ----------------------------------------------------------------------------
module multi_timer #(
    parameter int          NUM_CH         = 4,
    parameter int          CNT_W          = 32,
    parameter logic [31:0] DEFAULT_PERIOD = 32'h0001_869F,
    localparam int         ADDR_W         = $clog2(NUM_CH) + 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] pwm_out
);

    localparam int               CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] RST_PERIOD = DEFAULT_PERIOD[CNT_W-1:0];

    localparam logic [2:0] OFF_STATUS  = 3'd0;
    localparam logic [2:0] OFF_CONTROL = 3'd1;
    localparam logic [2:0] OFF_PERIOD  = 3'd2;
    localparam logic [2:0] OFF_COMPARE = 3'd3;
    localparam logic [2:0] OFF_COUNT   = 3'd4;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [2:0]      reg_off;
    logic [CH_W-1:0] ch_idx;
    logic            ch_valid;
    logic            wr_en;

    assign reg_off = address[2:0];

    if (NUM_CH > 1) begin : g_ch_idx
        assign ch_idx = address[ADDR_W-1:3];
    end else begin : g_ch_single
        assign ch_idx = '0;
    end

    // Channel indices at or above NUM_CH (possible when NUM_CH is not a
    // power of two) are holes in the map: reads give 0, writes are dropped.
    assign ch_valid = ({1'b0, ch_idx} < (CH_W + 1)'(NUM_CH));
    assign wr_en    = chipselect && !write_n && ch_valid;

    // ------------------------------------------------------------------
    // Per-channel state
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  count_q   [NUM_CH];
    logic [CNT_W-1:0]  period_q  [NUM_CH];
    logic [CNT_W-1:0]  compare_q [NUM_CH];
    logic [7:0]        presc_q   [NUM_CH];
    logic [7:0]        psc_cnt_q [NUM_CH];
    logic [NUM_CH-1:0] ito_q, cont_q, icf_q, pwm_en_q;
    logic [NUM_CH-1:0] run_q, to_q, cf_q, pwm_q;

    // Per-channel strobes and events for the current cycle
    logic [NUM_CH-1:0] wr_status, wr_control, wr_period, wr_compare;
    logic [NUM_CH-1:0] start_cmd, stop_cmd;
    logic [NUM_CH-1:0] tick, at_zero, to_set, cf_set;

    // NOTE: every output of an always_comb gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        wr_status  = '0;
        wr_control = '0;
        wr_period  = '0;
        wr_compare = '0;
        start_cmd  = '0;
        stop_cmd   = '0;
        tick       = '0;
        at_zero    = '0;
        to_set     = '0;
        cf_set     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_status[i]  = wr_en && (ch_idx == CH_W'(i)) && (reg_off == OFF_STATUS);
            wr_control[i] = wr_en && (ch_idx == CH_W'(i)) && (reg_off == OFF_CONTROL);
            wr_period[i]  = wr_en && (ch_idx == CH_W'(i)) && (reg_off == OFF_PERIOD);
            wr_compare[i] = wr_en && (ch_idx == CH_W'(i)) && (reg_off == OFF_COMPARE);

            // STOP wins over START when both are written together
            stop_cmd[i]  = wr_control[i] && writedata[3];
            start_cmd[i] = wr_control[i] && writedata[2] && !writedata[3];

            // A forced reload (PERIOD write) suppresses this cycle's tick
            tick[i]    = run_q[i] && (psc_cnt_q[i] == presc_q[i]) && !wr_period[i];
            at_zero[i] = (count_q[i] == '0);
            to_set[i]  = tick[i] && at_zero[i];
            cf_set[i]  = tick[i] && (count_q[i] == compare_q[i]);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    // NOTE: the per-channel arrays are flops, not a RAM macro, so they all
    // take their reset values; this lets a mid-count reset restart cleanly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                count_q[i]   <= RST_PERIOD;
                period_q[i]  <= RST_PERIOD;
                compare_q[i] <= '0;
                presc_q[i]   <= '0;
                psc_cnt_q[i] <= '0;
            end
            ito_q    <= '0;
            cont_q   <= '0;
            icf_q    <= '0;
            pwm_en_q <= '0;
            run_q    <= '0;
            to_q     <= '0;
            cf_q     <= '0;
            pwm_q    <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_period[i]) begin
                    // Forced reload: counter restarts from the new period and
                    // the channel waits for a fresh START
                    period_q[i]  <= writedata[CNT_W-1:0];
                    count_q[i]   <= writedata[CNT_W-1:0];
                    psc_cnt_q[i] <= '0;
                    run_q[i]     <= 1'b0;
                end else begin
                    if (tick[i]) begin
                        count_q[i] <= at_zero[i] ? period_q[i] : count_q[i] - CNT_W'(1);
                    end

                    if (start_cmd[i]) begin
                        psc_cnt_q[i] <= '0;
                    end else if (run_q[i]) begin
                        psc_cnt_q[i] <= tick[i] ? 8'd0 : psc_cnt_q[i] + 8'd1;
                    end

                    // START overrides the one-shot auto-stop in the same cycle
                    if (stop_cmd[i]) begin
                        run_q[i] <= 1'b0;
                    end else if (start_cmd[i]) begin
                        run_q[i] <= 1'b1;
                    end else if (to_set[i] && !cont_q[i]) begin
                        run_q[i] <= 1'b0;
                    end
                end

                if (wr_control[i]) begin
                    ito_q[i]    <= writedata[0];
                    cont_q[i]   <= writedata[1];
                    icf_q[i]    <= writedata[4];
                    pwm_en_q[i] <= writedata[5];
                    presc_q[i]  <= writedata[15:8];
                end

                if (wr_compare[i]) begin
                    compare_q[i] <= writedata[CNT_W-1:0];
                end

                // Flag set has priority over a same-cycle W1C
                to_q[i] <= to_set[i] || (to_q[i] && !(wr_status[i] && writedata[0]));
                cf_q[i] <= cf_set[i] || (cf_q[i] && !(wr_status[i] && writedata[2]));

                pwm_q[i] <= run_q[i] && pwm_en_q[i] && (count_q[i] < compare_q[i]);
            end
        end
    end

    assign pwm_out = pwm_q;
    assign irq     = |((to_q & ito_q) | (cf_q & icf_q));

    // ------------------------------------------------------------------
    // Read path: registered every cycle from address, independent of
    // chipselect; holes and unused offsets read 0.
    // ------------------------------------------------------------------
    logic [31:0] rd_next;

    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_idx == CH_W'(i)) begin
                case (reg_off)
                    OFF_STATUS:  rd_next = {29'd0, cf_q[i], run_q[i], to_q[i]};
                    OFF_CONTROL: rd_next = {16'd0, presc_q[i], 2'b00, pwm_en_q[i],
                                            icf_q[i], 2'b00, cont_q[i], ito_q[i]};
                    OFF_PERIOD:  rd_next = 32'(period_q[i]);
                    OFF_COMPARE: rd_next = 32'(compare_q[i]);
                    OFF_COUNT:   rd_next = 32'(count_q[i]);
                    default:     rd_next = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_next;
        end
    end

endmodule
